color_key_conditioner: RTL
==========================

// Module: color_key_conditioner
// PURPOSE
//  Front-end conditioner for the four code-lock push-buttons (Start, Red, Green, Blue).
//  Each raw, asynchronous, bouncy button input is synchronised, debounced, and edge-detected.
//  The block emits a single-cycle, glitch-free press pulse per button.
//  Outputs drive the Start/Red/Green/Blue inputs of the code detector FSM directly.
//  Idle output 0000 is the "no press" value that the detector holds state on.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a level change; legal range >= 2
//  CNT_W            16     debounce counter width; requires 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  Clk       in   1  system clock; all state changes on the rising edge
//  Rst       in   1  synchronous, active-high reset
//  StartRaw  in   1  raw Start button, async, active-high
//  RedRaw    in   1  raw Red button, async, active-high
//  GreenRaw  in   1  raw Green button, async, active-high
//  BlueRaw   in   1  raw Blue button, async, active-high
//  Start     out  1  one-cycle pulse on accepted Start press
//  Red       out  1  one-cycle pulse on accepted Red press
//  Green     out  1  one-cycle pulse on accepted Green press
//  Blue      out  1  one-cycle pulse on accepted Blue press
//  Conflict  out  1  present only with KEY_COLOR_LOCKOUT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: one clock (Clk); reset is synchronous and active-high (Rst).
//  Reset values:
//   - All outputs 0.
//   - Synchroniser flops 0, all channel FSMs in S_UP, all counters 0.
//  Channel structure: four identical, independent channels. Each channel has:
//   - a 2-flop synchroniser (raw -> q1 -> s);
//   - a CNT_W-bit counter;
//   - a 4-state FSM.
//  Channel FSM, evaluated each cycle on s:
//   - S_UP:     s=1 -> S_DN_CNT, cnt<=1; else stay.
//   - S_DN_CNT: s=0 -> S_UP, cnt<=0.
//               cnt==DEBOUNCE_CYCLES-1 -> S_DOWN, cnt<=0, pulse<=1.
//               else cnt<=cnt+1.
//   - S_DOWN:   s=0 -> S_UP_CNT, cnt<=1; else stay. No further pulses while held.
//   - S_UP_CNT: s=1 -> S_DOWN, cnt<=0 (bounce on release; no pulse).
//               cnt==DEBOUNCE_CYCLES-1 -> S_UP, cnt<=0.
//               else cnt<=cnt+1.
//  Outputs: registered; each pulse is high for exactly 1 cycle, then returns to 0.
//  Latency: raw held high, first sampled at edge 0 -> output high for the single cycle after edge DEBOUNCE_CYCLES+1.
//  Release: produces no output.
//   - A re-press is accepted only after the full release debounce completes (return to S_UP).
//  Glitches: any low->high glitch shorter than DEBOUNCE_CYCLES cycles (after sync) produces no pulse.
//  Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//  Simultaneous events, base build:
//   - Channels are fully independent.
//   - Multiple pulses in the same cycle are passed through unmodified; the downstream detector treats them as an invalid code.
//  Reset mid-operation: returns the channel to S_UP with cnt=0.
//   - A button held through reset is re-debounced from S_UP.
//   - It pulses DEBOUNCE_CYCLES+2 cycles after Rst deasserts.
// CONFIGURATION
//  KEY_COLOR_LOCKOUT_EN undefined:
//   - No Conflict port.
//   - Behaviour exactly as above.
//  KEY_COLOR_LOCKOUT_EN defined:
//   - A colour press that qualifies while a different colour channel is in S_DN_CNT, S_DOWN or S_UP_CNT is suppressed.
//   - The suppressed channel's FSM still advances to S_DOWN.
//   - Conflict pulses high for 1 cycle in place of the suppressed colour pulse.
//   - If two colours qualify in the same cycle, both are suppressed and Conflict pulses once.
//   - Start is never locked out.
//   - Conflict reset value is 0.
// TESTING  (bench with DEBOUNCE_CYCLES=4)
//  1. Clean press: RedRaw 0->1 held 20 cycles -> Red=1 in exactly one cycle, 5 edges after first sample; Start/Green/Blue stay 0.
//  2. Bounce: BlueRaw toggles 1,0,1,1,0 per cycle, then held 1 -> exactly one Blue pulse, timed from the final rising edge; release bounce -> no pulse.
//  3. Short glitch: GreenRaw high 3 cycles, then low -> Green never asserts; FSM back in S_UP.
//  4. Hold and re-press:
//     - StartRaw held 50 cycles -> exactly 1 pulse.
//     - Released 2 cycles, then pressed again -> no second pulse.
//     - Released 10 cycles, then pressed -> second pulse.
//  5. Mid-count reset: RedRaw high; Rst=1 for 1 cycle at cnt=2 -> Red=0 at reset; Red pulses once, 6 cycles after Rst deasserts.
//  6. Simultaneous: RedRaw and GreenRaw rise on the same cycle:
//     - base build -> Red=Green=1 in the same cycle;
//     - with KEY_COLOR_LOCKOUT_EN -> Red=Green=0 and Conflict=1 for one cycle.

Source files
------------

// File: rtl/color_key_conditioner.sv
// -----------------------------------------------------------------------------
// color_key_conditioner
//
// Purpose:
//   Conditions the four code-lock push-buttons (Start, Red, Green, Blue) for
//   the code detector FSM. Every raw button goes through its own channel:
//   a 2-flop synchroniser, a debounce counter and a 4-state FSM. An accepted
//   press produces a registered, single-cycle pulse. Releases never pulse.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   synchronous, active-high reset
//   StartRaw  in   raw Start button (async, active-high)
//   RedRaw    in   raw Red button   (async, active-high)
//   GreenRaw  in   raw Green button (async, active-high)
//   BlueRaw   in   raw Blue button  (async, active-high)
//   Start     out  one-cycle pulse per accepted Start press
//   Red       out  one-cycle pulse per accepted Red press
//   Green     out  one-cycle pulse per accepted Green press
//   Blue      out  one-cycle pulse per accepted Blue press
//   Conflict  out  only when KEY_COLOR_LOCKOUT_EN is defined
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a level change (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Optional feature (macro KEY_COLOR_LOCKOUT_EN):
//   A colour press that qualifies while another colour channel is not idle
//   is suppressed. A Conflict pulse is emitted in its place. Start is never
//   locked out.
// -----------------------------------------------------------------------------
module color_key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic StartRaw,
    input  logic RedRaw,
    input  logic GreenRaw,
    input  logic BlueRaw,
    output logic Start,
    output logic Red,
    output logic Green,
    output logic Blue
`ifdef KEY_COLOR_LOCKOUT_EN
    ,
    output logic Conflict
`endif
);

    typedef enum logic [1:0] {
        S_UP     = 2'd0,
        S_DN_CNT = 2'd1,
        S_DOWN   = 2'd2,
        S_UP_CNT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel index: 0 = Start, 1 = Red, 2 = Green, 3 = Blue
    logic [3:0]       raw;
    logic [3:0]       q1_q;
    logic [3:0]       s_q;
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;
    logic [3:0]       qualify;
    logic [3:0]       suppress;
    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

`ifdef KEY_COLOR_LOCKOUT_EN
    logic conflict_q;
    logic conflict_d;
`endif

    assign raw = {BlueRaw, GreenRaw, RedRaw, StartRaw};

    // Debounce FSM per channel. The counter counts consecutive cycles at the
    // new level; any return to the old level abandons the change. qualify
    // marks the cycle in which a press is accepted.
    always_comb begin
        qualify = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_UP: begin
                    if (s_q[i]) begin
                        state_d[i] = S_DN_CNT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_DN_CNT: begin
                    if (!s_q[i]) begin
                        state_d[i] = S_UP;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_DOWN;
                        cnt_d[i]   = '0;
                        qualify[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                S_DOWN: begin
                    if (!s_q[i]) begin
                        state_d[i] = S_UP_CNT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                S_UP_CNT: begin
                    // A bounce during release goes straight back to held.
                    if (s_q[i]) begin
                        state_d[i] = S_DOWN;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_UP;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = S_UP;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Output pulse selection. In the base build every qualified press passes.
    // With lockout, a colour (channels 1..3) is suppressed when any other
    // colour channel is away from S_UP; this also covers two colours
    // qualifying together, since each sees the other in S_DN_CNT.
    always_comb begin
        suppress = '0;
`ifdef KEY_COLOR_LOCKOUT_EN
        for (int i = 1; i < 4; i++) begin
            for (int j = 1; j < 4; j++) begin
                if ((i != j) && qualify[i] && (state_q[j] != S_UP)) begin
                    suppress[i] = 1'b1;
                end
            end
        end
        conflict_d = |suppress;
`endif
        pulse_d = qualify & ~suppress;
    end

    // All state and outputs registered; reset returns every channel to idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q1_q    <= '0;
            s_q     <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_UP;
                cnt_q[i]   <= '0;
            end
`ifdef KEY_COLOR_LOCKOUT_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            q1_q    <= raw;
            s_q     <= q1_q;
            pulse_q <= pulse_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef KEY_COLOR_LOCKOUT_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign Start = pulse_q[0];
    assign Red   = pulse_q[1];
    assign Green = pulse_q[2];
    assign Blue  = pulse_q[3];

`ifdef KEY_COLOR_LOCKOUT_EN
    assign Conflict = conflict_q;
`endif

endmodule
